// File: rtl/subcarrier_mapper.sv
// rtl/subcarrier_mapper.sv - bit-FIFO fed BPSK/QPSK OFDM subcarrier mapper; QPSK option macro SUBC_MAPPER_QPSK_EN
module subcarrier_mapper #(
    parameter int          FFT_SIZE   = 1024,
    parameter int          LO_END     = 400,
    parameter int          HI_START   = 623,
    parameter int          IN_WIDTH   = 32,
    parameter int          DEPTH_LOG2 = 11,
    parameter logic [15:0] BPSK_AMP   = 16'h7FFF,
    parameter logic [15:0] QPSK_AMP   = 16'h5A82
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reset_mod,
    input  logic                mod_sel,
    input  logic [IN_WIDTH-1:0] s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    output logic [31:0]         m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic [1:0]          st
);
    localparam int NDATA = LO_END + FFT_SIZE - 1 - HI_START;
    localparam int KW    = $clog2(FFT_SIZE);
    localparam int KW1   = KW + 1;
    localparam int CW    = DEPTH_LOG2 + 1;

    localparam logic [CW-1:0]  DEPTH_BITS = CW'(1 << DEPTH_LOG2);
    localparam logic [CW-1:0]  IN_BITS    = CW'(IN_WIDTH);
    localparam logic [CW-1:0]  BPS_BPSK   = CW'(NDATA);
    localparam logic [KW:0]    K_ONE      = KW1'(1);
    localparam logic [KW:0]    K_LO       = KW1'(LO_END);
    localparam logic [KW:0]    K_HI       = KW1'(HI_START);
    localparam logic [KW:0]    K_HI_END   = KW1'(FFT_SIZE - 2);
    localparam logic [KW:0]    K_LAST     = KW1'(FFT_SIZE - 1);
    localparam logic [KW:0]    K_END      = KW1'(FFT_SIZE);
    localparam logic [15:0]    BPSK_NEG   = ~BPSK_AMP + 16'd1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1} state_t;

    state_t                state_q, state_d;
    logic [KW:0]           gk_q, gk_d;          // index of the next sample to load
    logic [CW-1:0]         count_q;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  mem [0:(1 << DEPTH_LOG2) - 1];

    logic                  srst, wr_fire, load_en, start_ok, is_data, bit0;
    logic [CW-1:0]         wr_bits, rd_bits, bps_sel;
    logic [31:0]           map_word, data_d;
    logic                  valid_d, last_d;

`ifdef SUBC_MAPPER_QPSK_EN
    localparam logic [CW-1:0] BPS_QPSK = CW'(2 * NDATA);
    localparam logic [15:0]   QPSK_NEG = ~QPSK_AMP + 16'd1;
    logic mode_q, mode_d, bit1;
    assign bit1    = mem[rd_ptr + PTR_ONE];
    assign bps_sel = mod_sel ? BPS_QPSK : BPS_BPSK;
    assign map_word = mode_q ? {bit1 ? QPSK_AMP : QPSK_NEG, bit0 ? QPSK_AMP : QPSK_NEG}
                             : {16'h0000, bit0 ? BPSK_AMP : BPSK_NEG};
`else
    logic unused_mod_sel;
    assign unused_mod_sel = mod_sel;
    assign bps_sel  = BPS_BPSK;
    assign map_word = {16'h0000, bit0 ? BPSK_AMP : BPSK_NEG};
`endif

    assign srst     = !rst || reset_mod;
    assign s_tready = (DEPTH_BITS - count_q) >= IN_BITS;
    assign wr_fire  = s_tvalid && s_tready;
    assign wr_bits  = wr_fire ? IN_BITS : '0;
    assign load_en  = !m_tvalid || m_tready;
    assign start_ok = count_q >= bps_sel;
    assign bit0     = mem[rd_ptr];
    assign is_data  = ((gk_q >= K_ONE) && (gk_q <= K_LO)) || ((gk_q >= K_HI) && (gk_q <= K_HI_END));
    assign st       = state_q;

    // Next-state, next-sample and bit-consumption decisions
    always_comb begin
        state_d = state_q;
        gk_d    = gk_q;
        valid_d = m_tvalid;
        data_d  = m_tdata;
        last_d  = m_tlast;
        rd_bits = '0;
`ifdef SUBC_MAPPER_QPSK_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = ACTIVE;
                    gk_d    = K_ONE;
                    valid_d = 1'b1;
                    data_d  = 32'h0;
                    last_d  = 1'b0;
`ifdef SUBC_MAPPER_QPSK_EN
                    mode_d  = mod_sel;
`endif
                end
            end
            ACTIVE: begin
                if (load_en) begin
                    if (gk_q == K_END) begin
                        // final beat just accepted: chain the next symbol or fall idle
                        if (start_ok) begin
                            gk_d    = K_ONE;
                            valid_d = 1'b1;
                            data_d  = 32'h0;
                            last_d  = 1'b0;
`ifdef SUBC_MAPPER_QPSK_EN
                            mode_d  = mod_sel;
`endif
                        end else begin
                            state_d = IDLE;
                            gk_d    = '0;
                            valid_d = 1'b0;
                            data_d  = 32'h0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        valid_d = 1'b1;
                        last_d  = (gk_q == K_LAST);
                        gk_d    = gk_q + K_ONE;
                        data_d  = 32'h0;
                        if (is_data) begin
                            data_d  = map_word;
`ifdef SUBC_MAPPER_QPSK_EN
                            rd_bits = mode_q ? CW'(2) : CW'(1);
`else
                            rd_bits = CW'(1);
`endif
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control, pointer, count and output registers
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= IDLE;
            gk_q     <= '0;
            count_q  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= 32'h0;
            m_tlast  <= 1'b0;
`ifdef SUBC_MAPPER_QPSK_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gk_q     <= gk_d;
            count_q  <= count_q + wr_bits - rd_bits;
            wr_ptr   <= wr_fire ? wr_ptr + DEPTH_LOG2'(IN_WIDTH) : wr_ptr;
            rd_ptr   <= rd_ptr + rd_bits[DEPTH_LOG2-1:0];
            m_tvalid <= valid_d;
            m_tdata  <= data_d;
            m_tlast  <= last_d;
`ifdef SUBC_MAPPER_QPSK_EN
            mode_q   <= mode_d;
`endif
        end
    end

    // Bit storage, written LSB first at the write pointer; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                mem[wr_ptr + DEPTH_LOG2'(i)] <= s_tdata[i];
            end
        end
    end
endmodule

// File: tb/tb_subcarrier_mapper.sv
// tb/tb_subcarrier_mapper.sv - self-checking bench for subcarrier_mapper
module tb_subcarrier_mapper;
    localparam int FFT      = 1024;
    localparam int LO_END   = 400;
    localparam int HI_START = 623;
    localparam int NDATA    = LO_END + FFT - 1 - HI_START;
`ifdef SUBC_MAPPER_QPSK_EN
    localparam bit QPSK_EN = 1'b1;
`else
    localparam bit QPSK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, reset_mod, mod_sel, s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
    logic [31:0] s_tdata, m_tdata;
    logic [1:0]  st;

    int total = 0;
    int bad   = 0;
    int stall_err = 0;

    bit          in_bits[$];
    logic [32:0] out_q[$];
    logic [32:0] exp_q[$];
    bit          prev_stall = 1'b0;
    logic [32:0] prev_out;

    subcarrier_mapper dut (
        .clk(clk), .rst(rst), .reset_mod(reset_mod), .mod_sel(mod_sel),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .st(st)
    );

    always #5 clk = ~clk;

    // Capture accepted input bits and output beats, watch stall stability
    always @(negedge clk) begin
        if (rst && !reset_mod) begin
            if (s_tvalid && s_tready)
                for (int i = 0; i < 32; i++) in_bits.push_back(s_tdata[i]);
            if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
            if (prev_stall && ({m_tlast, m_tdata} !== prev_out)) stall_err++;
        end
        prev_stall = m_tvalid && !m_tready && rst && !reset_mod;
        prev_out   = {m_tlast, m_tdata};
    end

    // Reference: complete symbols from the captured bit stream, bins mapped by rule
    function automatic void build_expected(input bit qpsk);
        int bps;
        int pos;
        logic [31:0] d;
        bps = qpsk ? 2 * NDATA : NDATA;
        pos = 0;
        exp_q.delete();
        while (in_bits.size() - pos >= bps) begin
            for (int k = 0; k < FFT; k++) begin
                d = 32'h0;
                if ((k >= 1 && k <= LO_END) || (k >= HI_START && k <= FFT - 2)) begin
                    if (qpsk) begin
                        d = {in_bits[pos+1] ? 16'h5A82 : 16'hA57E, in_bits[pos] ? 16'h5A82 : 16'hA57E};
                        pos += 2;
                    end else begin
                        d = in_bits[pos] ? 32'h00007FFF : 32'h00008001;
                        pos += 1;
                    end
                end
                exp_q.push_back({k == FFT - 1, d});
            end
        end
    endfunction

    task automatic do_reset();
        rst = 1'b0; reset_mod = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0; s_tdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        in_bits.delete();
        out_q.delete();
    endtask

    task automatic send_words(input int n, input bit rnd, input logic [31:0] val, output bit ok);
        int c;
        ok = 1'b1;
        for (int w = 0; w < n && ok; w++) begin
            c = 0;
            s_tdata  = rnd ? $urandom : val;
            s_tvalid = 1'b1;
            @(negedge clk);
            while (!s_tready && c < 20000) begin
                @(negedge clk);
                c++;
            end
            if (!s_tready) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (out_q.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        ok = (out_q.size() >= n);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
        total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b exp=0", m_tlast); end
        total++; if (m_tdata !== 32'h0) begin bad++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
        total++; if (st !== 2'd0) begin bad++; $display("FAIL reset_st got=%0d exp=0", st); end
        total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL reset_tready got=%b exp=1", s_tready); end
    endtask

    task automatic test_bpsk_ones();
        bit ok;
        do_reset();
        mod_sel = 1'b0; m_tready = 1'b1;
        send_words(25, 1'b0, 32'hFFFFFFFF, ok);
        wait_beats(FFT, 3000, ok);
        build_expected(1'b0);
        total++; if (out_q.size() !== FFT) begin bad++; $display("FAIL bpsk_count got=%0d exp=%0d", out_q.size(), FFT); end
        if (out_q.size() >= FFT) begin
            total++; if (out_q[1] !== {1'b0, 32'h00007FFF}) begin bad++; $display("FAIL bpsk_k1 got=%h exp=00007fff", out_q[1]); end
            total++; if (out_q[401] !== 33'h0) begin bad++; $display("FAIL bpsk_k401 got=%h exp=0", out_q[401]); end
            total++; if (out_q[1022] !== {1'b0, 32'h00007FFF}) begin bad++; $display("FAIL bpsk_k1022 got=%h exp=00007fff", out_q[1022]); end
            total++; if (out_q[1023] !== {1'b1, 32'h0}) begin bad++; $display("FAIL bpsk_k1023 got=%h exp=100000000", out_q[1023]); end
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL bpsk_beat%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_underrun();
        bit ok;
        do_reset();
        mod_sel = 1'b0; m_tready = 1'b1;
        send_words(24, 1'b1, 32'h0, ok);
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL underrun_tvalid got=%b exp=0", m_tvalid); end
        total++; if (st !== 2'd0) begin bad++; $display("FAIL underrun_st got=%0d exp=0", st); end
        send_words(1, 1'b1, 32'h0, ok);
        @(posedge clk);
        @(negedge clk);
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL start_tvalid got=%b exp=1", m_tvalid); end
        total++; if (st !== 2'd1) begin bad++; $display("FAIL start_st got=%0d exp=1", st); end
        wait_beats(FFT, 3000, ok);
        build_expected(1'b0);
        total++; if (out_q.size() !== exp_q.size()) begin bad++; $display("FAIL underrun_count got=%0d exp=%0d", out_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL underrun_beat%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_qpsk();
        bit ok;
        logic [32:0] exp1;
        do_reset();
        mod_sel = 1'b1; m_tready = 1'b1;
        send_words(50, 1'b0, 32'h55555555, ok);
        build_expected(QPSK_EN);
        wait_beats(exp_q.size(), 5000, ok);
        exp1 = QPSK_EN ? {1'b0, 32'hA57E5A82} : {1'b0, 32'h00007FFF};
        total++; if (out_q.size() !== exp_q.size()) begin bad++; $display("FAIL qpsk_count got=%0d exp=%0d", out_q.size(), exp_q.size()); end
        if (out_q.size() > 1) begin
            total++; if (out_q[1] !== exp1) begin bad++; $display("FAIL qpsk_k1 got=%h exp=%h", out_q[1], exp1); end
        end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL qpsk_beat%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
        end
        mod_sel = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok_in, ok_out;
        do_reset();
        mod_sel = 1'b0;
        stall_err = 0;
        fork
            send_words(75, 1'b1, 32'h0, ok_in);
            begin
                int c;
                c = 0;
                while (out_q.size() < 3 * FFT && c < 40000) begin
                    @(posedge clk);
                    #1 m_tready = ($urandom_range(0, 9) < 3);
                    c++;
                end
                m_tready = 1'b1;
            end
        join
        wait_beats(3 * FFT, 3000, ok_out);
        build_expected(1'b0);
        total++; if (ok_in !== 1'b1) begin bad++; $display("FAIL bp_input_timeout got=%b exp=1", ok_in); end
        total++; if (out_q.size() !== 3 * FFT) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", out_q.size(), 3 * FFT); end
        total++; if (stall_err !== 0) begin bad++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_beat%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int gaps;
        do_reset();
        mod_sel = 1'b0;
        send_words(50, 1'b1, 32'h0, ok);
        @(posedge clk);
        #1 m_tready = 1'b1;
        gaps = 0;
        for (int c = 0; c < 2 * FFT; c++) begin
            @(negedge clk);
            if (!m_tvalid) gaps++;
        end
        repeat (3) @(posedge clk);
        build_expected(1'b0);
        total++; if (gaps !== 0) begin bad++; $display("FAIL b2b_gaps got=%0d exp=0", gaps); end
        total++; if (out_q.size() !== 2 * FFT) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", out_q.size(), 2 * FFT); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mod();
        bit ok;
        int c, lasts;
        do_reset();
        mod_sel = 1'b0; m_tready = 1'b1;
        send_words(25, 1'b1, 32'h0, ok);
        c = 0;
        while (out_q.size() < 500 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        #1 m_tready = 1'b0; reset_mod = 1'b1;
        @(posedge clk);
        #1 reset_mod = 1'b0;
        @(negedge clk);
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rm_tvalid got=%b exp=0", m_tvalid); end
        total++; if (st !== 2'd0) begin bad++; $display("FAIL rm_st got=%0d exp=0", st); end
        total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL rm_tready got=%b exp=1", s_tready); end
        lasts = 0;
        foreach (out_q[i]) if (out_q[i][32]) lasts++;
        total++; if (out_q.size() !== 500) begin bad++; $display("FAIL rm_aborted_count got=%0d exp=500", out_q.size()); end
        total++; if (lasts !== 0) begin bad++; $display("FAIL rm_aborted_tlast got=%0d exp=0", lasts); end
        in_bits.delete();
        out_q.delete();
        m_tready = 1'b1;
        send_words(25, 1'b1, 32'h0, ok);
        wait_beats(FFT, 3000, ok);
        build_expected(1'b0);
        total++; if (out_q.size() !== FFT) begin bad++; $display("FAIL rm_fresh_count got=%0d exp=%0d", out_q.size(), FFT); end
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            total++;
            if (out_q[i] !== exp_q[i]) begin bad++; $display("FAIL rm_beat%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst = 1'b0; reset_mod = 1'b0; mod_sel = 1'b0;
        s_tvalid = 1'b0; s_tdata = 32'h0; m_tready = 1'b0;
        test_reset();
        test_bpsk_ones();
        test_underrun();
        test_qpsk();
        test_backpressure();
        test_back_to_back();
        test_reset_mod();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
